// File: rtl/pid_pos_controller_mc.sv
`default_nettype none
// ============================================================================
// Module      : pid_pos_controller_mc
// Description : Multi-axis position PID controller. A single shared multiplier
//               is time-multiplexed over NUM_AXES axes once per sample tick.
//               It has sign-aware anti-windup, a global enable that clears all
//               state, and a frame-done strobe.
//               Optional macro PID_DERIV_FILTER_EN adds a first-order (1/4)
//               low-pass filter on the derivative term.
// Revision    : 1.0 - initial release
// ============================================================================
module pid_pos_controller_mc #(
  parameter int NUM_AXES   = 2,
  parameter int POS_W      = 32,
  parameter int GAIN_W     = 16,
  parameter int GAIN_FRAC  = 8,
  parameter int OUT_W      = 16,
  parameter int OUT_LIMIT  = 4000,
  parameter int INT_LIMIT  = 2000000000,
  parameter int SAMPLE_DIV = 5000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic [NUM_AXES*POS_W-1:0]  desired_pos,
  input  logic [NUM_AXES*POS_W-1:0]  actual_pos,
  input  logic [NUM_AXES*GAIN_W-1:0] kp,
  input  logic [NUM_AXES*GAIN_W-1:0] ki,
  input  logic [NUM_AXES*GAIN_W-1:0] kd,
  output logic [NUM_AXES*OUT_W-1:0]  control_signal,
  output logic                       update_valid,
  output logic                       busy
);

  localparam int AX_W  = (NUM_AXES > 1) ? $clog2(NUM_AXES) : 1;
  localparam int CNT_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int PRD_W = POS_W + GAIN_W;
  localparam int ACC_W = POS_W + GAIN_W + 2;

  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_LOAD  = 4'd1;
  localparam logic [3:0] S_INTEG = 4'd2;
  localparam logic [3:0] S_MUL_P = 4'd3;
  localparam logic [3:0] S_MUL_I = 4'd4;
  localparam logic [3:0] S_MUL_D = 4'd5;
  localparam logic [3:0] S_SAT   = 4'd6;
  localparam logic [3:0] S_WRITE = 4'd7;
  localparam logic [3:0] S_DONE  = 4'd8;

  localparam logic signed [POS_W:0]   INT_HI   = (POS_W+1)'(INT_LIMIT);
  localparam logic signed [POS_W:0]   INT_LO   = -INT_HI;
  localparam logic signed [POS_W-1:0] INT_HI_N = POS_W'(INT_LIMIT);
  localparam logic signed [POS_W-1:0] INT_LO_N = -INT_HI_N;
  localparam logic signed [ACC_W-1:0] ACC_HI   = ACC_W'(OUT_LIMIT);
  localparam logic signed [ACC_W-1:0] ACC_LO   = -ACC_HI;
  localparam logic signed [OUT_W-1:0] Y_HI     = OUT_W'(OUT_LIMIT);
  localparam logic signed [OUT_W-1:0] Y_LO     = -Y_HI;
  localparam logic [CNT_W-1:0]        CNT_LAST = CNT_W'(SAMPLE_DIV - 1);
  localparam logic [AX_W-1:0]         AX_LAST  = AX_W'(NUM_AXES - 1);

  // A frame must always finish before the next tick can arrive.
  generate
    if ((SAMPLE_DIV < 7*NUM_AXES + 2) || (NUM_AXES < 1) || (NUM_AXES > 8)) begin : g_param_check
      $fatal(1, "pid_pos_controller_mc: illegal NUM_AXES / SAMPLE_DIV combination");
    end
  endgenerate

  // Saturate a POS_W+1 bit signed value into POS_W bits.
  function automatic logic signed [POS_W-1:0] sat_pos(input logic signed [POS_W:0] s);
    if (s[POS_W] != s[POS_W-1])
      sat_pos = s[POS_W] ? {1'b1, {(POS_W-1){1'b0}}} : {1'b0, {(POS_W-1){1'b1}}};
    else
      sat_pos = s[POS_W-1:0];
  endfunction

  logic [3:0]               state;
  logic [AX_W-1:0]          axis;
  logic [CNT_W-1:0]         count;
  logic signed [POS_W-1:0]  err;
  logic signed [POS_W-1:0]  delta;
  logic signed [GAIN_W-1:0] kp_q;
  logic signed [GAIN_W-1:0] ki_q;
  logic signed [GAIN_W-1:0] kd_q;
  logic signed [ACC_W-1:0]  acc;
  logic signed [OUT_W-1:0]  y;
  logic signed [POS_W-1:0]  integ    [NUM_AXES];
  logic signed [POS_W-1:0]  prev_err [NUM_AXES];
  logic signed [OUT_W-1:0]  lane     [NUM_AXES];
`ifdef PID_DERIV_FILTER_EN
  logic signed [POS_W-1:0]  dfilt    [NUM_AXES];
  logic signed [POS_W:0]    d_diff;
  logic signed [POS_W:0]    d_step;
  logic signed [POS_W:0]    d_sum;
  logic signed [POS_W-1:0]  dfilt_next;
`endif

  logic signed [POS_W-1:0]  des_a [NUM_AXES];
  logic signed [POS_W-1:0]  act_a [NUM_AXES];
  logic signed [GAIN_W-1:0] kp_a  [NUM_AXES];
  logic signed [GAIN_W-1:0] ki_a  [NUM_AXES];
  logic signed [GAIN_W-1:0] kd_a  [NUM_AXES];

  generate
    for (genvar k = 0; k < NUM_AXES; k++) begin : g_lane
      assign des_a[k] = desired_pos[k*POS_W +: POS_W];
      assign act_a[k] = actual_pos[k*POS_W +: POS_W];
      assign kp_a[k]  = kp[k*GAIN_W +: GAIN_W];
      assign ki_a[k]  = ki[k*GAIN_W +: GAIN_W];
      assign kd_a[k]  = kd[k*GAIN_W +: GAIN_W];
      assign control_signal[k*OUT_W +: OUT_W] = lane[k];
    end
  endgenerate

  logic signed [POS_W:0]    err_wide;
  logic signed [POS_W:0]    delta_wide;
  logic signed [POS_W:0]    isum;
  logic signed [POS_W-1:0]  err_sat;
  logic signed [POS_W-1:0]  delta_sat;
  logic signed [POS_W-1:0]  integ_next;
  logic signed [POS_W-1:0]  d_term;
  logic signed [GAIN_W-1:0] mul_g;
  logic signed [POS_W-1:0]  mul_x;
  logic signed [PRD_W-1:0]  prod;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W-1:0]  acc_shr;
  logic                     hold;

  // Datapath: error/derivative, integrator update, shared multiplier, scaling.
  always_comb begin
    err_wide   = {des_a[axis][POS_W-1], des_a[axis]} - {act_a[axis][POS_W-1], act_a[axis]};
    err_sat    = sat_pos(err_wide);
    delta_wide = {err_sat[POS_W-1], err_sat} - {prev_err[axis][POS_W-1], prev_err[axis]};
    delta_sat  = sat_pos(delta_wide);

    isum = {integ[axis][POS_W-1], integ[axis]} + {err[POS_W-1], err};
    if (isum > INT_HI)
      integ_next = INT_HI_N;
    else if (isum < INT_LO)
      integ_next = INT_LO_N;
    else
      integ_next = isum[POS_W-1:0];

    // Freeze the integrator while the output is pinned and the error pushes further.
    hold = ((lane[axis] == Y_HI) && !err[POS_W-1] && (err != '0)) ||
           ((lane[axis] == Y_LO) && err[POS_W-1]);

`ifdef PID_DERIV_FILTER_EN
    d_diff     = {delta[POS_W-1], delta} - {dfilt[axis][POS_W-1], dfilt[axis]};
    d_step     = d_diff >>> 2;
    d_sum      = {dfilt[axis][POS_W-1], dfilt[axis]} + d_step;
    dfilt_next = sat_pos(d_sum);
    d_term     = dfilt[axis];
`else
    d_term     = delta;
`endif

    case (state)
      S_MUL_I: begin mul_g = ki_q; mul_x = integ[axis]; end
      S_MUL_D: begin mul_g = kd_q; mul_x = d_term;      end
      default: begin mul_g = kp_q; mul_x = err;         end
    endcase
    prod     = $signed({{POS_W{mul_g[GAIN_W-1]}}, mul_g}) *
               $signed({{GAIN_W{mul_x[POS_W-1]}}, mul_x});
    prod_ext = {{2{prod[PRD_W-1]}}, prod};
    acc_shr  = acc >>> GAIN_FRAC;
  end

  // Free-running sample divider; tick is count == 0.
  always_ff @(posedge clk) begin
    if (reset || (count == CNT_LAST))
      count <= '0;
    else
      count <= count + 1'b1;
  end

  // Frame sequencer and per-axis state; enable low aborts and clears everything.
  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      state <= S_IDLE;
      axis  <= '0;
      err   <= '0;
      delta <= '0;
      kp_q  <= '0;
      ki_q  <= '0;
      kd_q  <= '0;
      acc   <= '0;
      y     <= '0;
      for (int k = 0; k < NUM_AXES; k++) begin
        integ[k]    <= '0;
        prev_err[k] <= '0;
        lane[k]     <= '0;
`ifdef PID_DERIV_FILTER_EN
        dfilt[k]    <= '0;
`endif
      end
    end else begin
      case (state)
        S_IDLE: begin
          if (count == '0) begin
            state <= S_LOAD;
            axis  <= '0;
          end
        end
        S_LOAD: begin
          err   <= err_sat;
          delta <= delta_sat;
          kp_q  <= kp_a[axis];
          ki_q  <= ki_a[axis];
          kd_q  <= kd_a[axis];
          state <= S_INTEG;
        end
        S_INTEG: begin
          if (!hold)
            integ[axis] <= integ_next;
`ifdef PID_DERIV_FILTER_EN
          dfilt[axis] <= dfilt_next;
`endif
          state <= S_MUL_P;
        end
        S_MUL_P: begin
          acc   <= prod_ext;
          state <= S_MUL_I;
        end
        S_MUL_I: begin
          acc   <= acc + prod_ext;
          state <= S_MUL_D;
        end
        S_MUL_D: begin
          acc   <= acc + prod_ext;
          state <= S_SAT;
        end
        S_SAT: begin
          if (acc_shr > ACC_HI)
            y <= Y_HI;
          else if (acc_shr < ACC_LO)
            y <= Y_LO;
          else
            y <= acc_shr[OUT_W-1:0];
          state <= S_WRITE;
        end
        S_WRITE: begin
          lane[axis]     <= y;
          prev_err[axis] <= err;
          if (axis == AX_LAST) begin
            state <= S_DONE;
          end else begin
            axis  <= axis + 1'b1;
            state <= S_LOAD;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign update_valid = (state == S_DONE);
  assign busy         = (state != S_IDLE);

endmodule
`default_nettype wire
